// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder for one 256-byte page beside the softcore RAM:
// GPIO port, small TX FIFO drained over valid/ready, and a 16-bit down-counter.
module mmio_responder #(
  parameter logic [7:0]  IO_BASE    = 8'hFF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  data,
  input  logic        rden,
  input  logic        wren,
  output logic [7:0]  q,
  output logic        io_hit,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_EMPTY = {OCC_W{1'b0}};

  localparam logic [7:0] OFS_GPIO_OUT  = 8'h00;
  localparam logic [7:0] OFS_GPIO_IN   = 8'h01;
  localparam logic [7:0] OFS_TX_DATA   = 8'h02;
  localparam logic [7:0] OFS_STATUS    = 8'h03;
  localparam logic [7:0] OFS_RELOAD_LO = 8'h04;
  localparam logic [7:0] OFS_RELOAD_HI = 8'h05;
  localparam logic [7:0] OFS_TCTRL     = 8'h06;

  // Bus decode
  logic       page_hit_s;
  logic       wr_acc_s;
  logic       rd_acc_s;
  logic [7:0] offset_s;
  logic       wr_gpio_s;
  logic       wr_tx_s;
  logic       wr_status_s;
  logic       wr_rld_lo_s;
  logic       wr_rld_hi_s;
  logic       wr_tctrl_s;
  logic [7:0] rd_data_s;
  logic [7:0] status_s;

  // Registered bus outputs and GPIO
  logic [7:0] q_r;
  logic       io_hit_r;
  logic [7:0] gpio_out_r;
  logic [7:0] gpio_sync1_r;
  logic [7:0] gpio_sync2_r;

  // FIFO state
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic             tx_valid_r;
  logic [7:0]       tx_data_r;
  logic             overflow_r;
  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic             push_s;
  logic             ovf_set_s;
  logic [PTR_W-1:0] wr_ptr_next_s;
  logic [PTR_W-1:0] rd_ptr_next_s;
  logic [OCC_W-1:0] occ_next_s;
  logic [7:0]       head_next_s;
  logic             overflow_next_s;

  // Timer state
  logic [15:0] reload_r;
  logic [15:0] count_r;
  logic        enable_r;
  logic        auto_reload_r;
  logic        expired_r;
  logic [15:0] count_next_s;
  logic        enable_next_s;
  logic        auto_next_s;
  logic        exp_set_s;
  logic        expired_next_s;

  assign page_hit_s = (address[15:8] == IO_BASE);
  assign wr_acc_s   = wren && page_hit_s;
  assign rd_acc_s   = rden && !wren;
  assign offset_s   = address[7:0];

  // Register-write strobes for an accepted write
  always_comb begin
    wr_gpio_s   = 1'b0;
    wr_tx_s     = 1'b0;
    wr_status_s = 1'b0;
    wr_rld_lo_s = 1'b0;
    wr_rld_hi_s = 1'b0;
    wr_tctrl_s  = 1'b0;
    if (wr_acc_s) begin
      case (offset_s)
        OFS_GPIO_OUT:  wr_gpio_s   = 1'b1;
        OFS_TX_DATA:   wr_tx_s     = 1'b1;
        OFS_STATUS:    wr_status_s = 1'b1;
        OFS_RELOAD_LO: wr_rld_lo_s = 1'b1;
        OFS_RELOAD_HI: wr_rld_hi_s = 1'b1;
        OFS_TCTRL:     wr_tctrl_s  = 1'b1;
        default:       wr_gpio_s   = 1'b0;
      endcase
    end else begin
      wr_gpio_s = 1'b0;
    end
  end

  assign full_s   = (occ_r == OCC_FULL);
  assign empty_s  = (occ_r == OCC_EMPTY);
  assign status_s = {1'b0, 3'(occ_r), overflow_r, expired_r, empty_s, full_s};

  // Read-data mux from current (pre-write) register values
  always_comb begin
    rd_data_s = 8'h00;
    case (offset_s)
      OFS_GPIO_OUT:  rd_data_s = gpio_out_r;
      OFS_GPIO_IN:   rd_data_s = gpio_sync2_r;
      OFS_STATUS:    rd_data_s = status_s;
      OFS_RELOAD_LO: rd_data_s = reload_r[7:0];
      OFS_RELOAD_HI: rd_data_s = reload_r[15:8];
      OFS_TCTRL:     rd_data_s = {6'b000000, auto_reload_r, enable_r};
      default:       rd_data_s = 8'h00;
    endcase
  end

  // Read response register; holds between accepted reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r      <= 8'h00;
      io_hit_r <= 1'b0;
    end else if (rd_acc_s) begin
      if (page_hit_s) begin
        q_r      <= rd_data_s;
        io_hit_r <= 1'b1;
      end else begin
        q_r      <= 8'h00;
        io_hit_r <= 1'b0;
      end
    end
  end

  // GPIO output register and two-flop input synchronizer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out_r   <= 8'h00;
      gpio_sync1_r <= 8'h00;
      gpio_sync2_r <= 8'h00;
    end else begin
      gpio_sync1_r <= gpio_in;
      gpio_sync2_r <= gpio_sync1_r;
      if (wr_gpio_s) begin
        gpio_out_r <= data;
      end
    end
  end

  assign pop_s     = tx_valid_r && tx_ready;
  assign push_s    = wr_tx_s && (!full_s || pop_s);
  assign ovf_set_s = wr_tx_s && full_s && !pop_s;

  // FIFO next state; the registered head is computed from post-update state
  always_comb begin
    wr_ptr_next_s   = wr_ptr_r;
    rd_ptr_next_s   = rd_ptr_r;
    occ_next_s      = occ_r;
    head_next_s     = 8'h00;
    overflow_next_s = overflow_r;
    if (push_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + OCC_W'(1);
      2'b01:   occ_next_s = occ_r - OCC_W'(1);
      default: occ_next_s = occ_r;
    endcase
    if (occ_next_s == OCC_EMPTY) begin
      head_next_s = 8'h00;
    end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
    // Hardware set wins over a same-cycle W1C
    if (ovf_set_s) begin
      overflow_next_s = 1'b1;
    end else if (wr_status_s && data[3]) begin
      overflow_next_s = 1'b0;
    end else begin
      overflow_next_s = overflow_r;
    end
  end

  // FIFO storage, pointers, occupancy and registered stream outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      occ_r      <= OCC_EMPTY;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= data;
      end
      wr_ptr_r   <= wr_ptr_next_s;
      rd_ptr_r   <= rd_ptr_next_s;
      occ_r      <= occ_next_s;
      tx_valid_r <= (occ_next_s != OCC_EMPTY);
      tx_data_r  <= head_next_s;
      overflow_r <= overflow_next_s;
    end
  end

  // Timer next state: TCTRL writes take priority over counting
  always_comb begin
    count_next_s  = count_r;
    enable_next_s = enable_r;
    auto_next_s   = auto_reload_r;
    exp_set_s     = 1'b0;
    if (wr_tctrl_s && !data[0]) begin
      enable_next_s = 1'b0;
      auto_next_s   = data[1];
    end else if (wr_tctrl_s && !enable_r) begin
      enable_next_s = 1'b1;
      auto_next_s   = data[1];
      count_next_s  = reload_r;
    end else begin
      if (wr_tctrl_s) begin
        auto_next_s = data[1];
      end else begin
        auto_next_s = auto_reload_r;
      end
      if (enable_r) begin
        if (count_r == 16'h0000) begin
          exp_set_s = 1'b1;
          if (auto_reload_r) begin
            count_next_s = reload_r;
          end else begin
            enable_next_s = 1'b0;
          end
        end else begin
          count_next_s = count_r - 16'h0001;
        end
      end else begin
        count_next_s = count_r;
      end
    end
    if (exp_set_s) begin
      expired_next_s = 1'b1;
    end else if (wr_status_s && data[2]) begin
      expired_next_s = 1'b0;
    end else begin
      expired_next_s = expired_r;
    end
  end

  // Timer registers and reload value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_r      <= 16'h0000;
      count_r       <= 16'h0000;
      enable_r      <= 1'b0;
      auto_reload_r <= 1'b0;
      expired_r     <= 1'b0;
    end else begin
      if (wr_rld_lo_s) begin
        reload_r[7:0] <= data;
      end
      if (wr_rld_hi_s) begin
        reload_r[15:8] <= data;
      end
      count_r       <= count_next_s;
      enable_r      <= enable_next_s;
      auto_reload_r <= auto_next_s;
      expired_r     <= expired_next_s;
    end
  end

  assign q        = q_r;
  assign io_hit   = io_hit_r;
  assign gpio_out = gpio_out_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: read and TX-stream scoreboards checked
// with immediate assertions.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data;
  logic        rden;
  logic        wren;
  logic [7:0]  q;
  logic        io_hit;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int errors = 0;
  int checks = 0;
  logic [8:0] rd_exp_q [$];
  logic [7:0] tx_exp_q [$];

  mmio_responder #(.IO_BASE(8'hFF), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .address(address), .data(data),
    .rden(rden), .wren(wren), .q(q), .io_hit(io_hit),
    .gpio_in(gpio_in), .gpio_out(gpio_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    address = a;
    data    = d;
    wren    = 1'b1;
    rden    = 1'b0;
    tick();
    wren    = 1'b0;
  endtask

  task automatic bus_rd(input string tag, input logic [15:0] a,
                        input logic [7:0] exp_q, input logic exp_hit);
    logic [8:0] e;
    address = a;
    rden    = 1'b1;
    wren    = 1'b0;
    rd_exp_q.push_back({exp_hit, exp_q});
    tick();
    rden = 1'b0;
    e = rd_exp_q.pop_front();
    check8({tag, "_q"}, q, e[7:0]);
    check1({tag, "_hit"}, io_hit, e[8]);
  endtask

  task automatic drain(input string tag, input int n);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check1({tag, "_valid"}, tx_valid, 1'b1);
      check8({tag, "_data"}, tx_data, tx_exp_q.pop_front());
      tick();
    end
    check1({tag, "_end_valid"}, tx_valid, 1'b0);
    check8({tag, "_end_data"}, tx_data, 8'h00);
    tx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = 16'h0000; data = 8'h00; rden = 1'b0; wren = 1'b0;
    gpio_in = 8'h00; tx_ready = 1'b0;
    #2 reset = 1'b0;
    tick();
    tick();
    check8("rst_q", q, 8'h00);
    check1("rst_hit", io_hit, 1'b0);
    check8("rst_gpio", gpio_out, 8'h00);
    check1("rst_valid", tx_valid, 1'b0);
    check8("rst_txdata", tx_data, 8'h00);
    reset = 1'b1;
    tick();
    bus_rd("rst_status", 16'hFF03, 8'h02, 1'b1);

    // GPIO and bus decode
    bus_wr(16'hFF00, 8'h5A);
    check8("gpio_out", gpio_out, 8'h5A);
    bus_rd("gpio_rd", 16'hFF00, 8'h5A, 1'b1);
    address = 16'hFF00; data = 8'h33; wren = 1'b1; rden = 1'b1;
    tick();
    wren = 1'b0; rden = 1'b0;
    check8("both_q_hold", q, 8'h5A);
    check1("both_hit_hold", io_hit, 1'b1);
    check8("both_gpio", gpio_out, 8'h33);
    bus_rd("off_page", 16'h1234, 8'h00, 1'b0);
    bus_wr(16'hFE00, 8'h11);
    check8("off_page_wr", gpio_out, 8'h33);
    bus_wr(16'hFF07, 8'hAA);
    bus_rd("unmapped", 16'hFF07, 8'h00, 1'b1);
    bus_rd("txdata_rd", 16'hFF02, 8'h00, 1'b1);
    gpio_in = 8'hC3;
    tick();
    tick();
    bus_rd("gpio_in", 16'hFF01, 8'hC3, 1'b1);
    gpio_in = 8'h3C;
    tick();
    bus_rd("gpio_in_lag", 16'hFF01, 8'hC3, 1'b1);
    bus_rd("gpio_in_new", 16'hFF01, 8'h3C, 1'b1);

    // Timer with auto-reload: period 4, W1C race on an expiry cycle
    bus_wr(16'hFF04, 8'h03);
    bus_wr(16'hFF05, 8'h00);
    bus_rd("rld_lo", 16'hFF04, 8'h03, 1'b1);
    bus_wr(16'hFF06, 8'h03);
    for (int i = 0; i < 4; i++) begin
      bus_rd("tmr_pre", 16'hFF03, 8'h02, 1'b1);
    end
    bus_rd("tmr_exp1", 16'hFF03, 8'h06, 1'b1);
    bus_wr(16'hFF03, 8'h04);
    bus_rd("tmr_clr", 16'hFF03, 8'h02, 1'b1);
    bus_rd("tmr_pre2", 16'hFF03, 8'h02, 1'b1);
    bus_rd("tmr_exp2", 16'hFF03, 8'h06, 1'b1);
    bus_wr(16'hFF03, 8'h04);
    tick();
    bus_wr(16'hFF03, 8'h04);
    bus_rd("w1c_race", 16'hFF03, 8'h06, 1'b1);
    bus_rd("tctrl_rd", 16'hFF06, 8'h03, 1'b1);
    bus_wr(16'hFF06, 8'h00);
    bus_wr(16'hFF03, 8'h04);
    bus_rd("stopped", 16'hFF03, 8'h02, 1'b1);
    repeat (4) tick();
    bus_rd("frozen", 16'hFF03, 8'h02, 1'b1);

    // Single-shot timer
    bus_wr(16'hFF06, 8'h01);
    bus_rd("one_tctrl", 16'hFF06, 8'h01, 1'b1);
    tick();
    tick();
    bus_rd("one_pre", 16'hFF06, 8'h01, 1'b1);
    bus_rd("one_done", 16'hFF06, 8'h00, 1'b1);
    bus_rd("one_exp", 16'hFF03, 8'h06, 1'b1);

    // FIFO overflow and drain
    bus_wr(16'hFF02, 8'h01);
    check1("first_valid", tx_valid, 1'b1);
    check8("first_data", tx_data, 8'h01);
    for (int i = 2; i <= 5; i++) begin
      bus_wr(16'hFF02, 8'(i));
    end
    bus_rd("fifo_full", 16'hFF03, 8'h4D, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tx_exp_q.push_back(8'(i));
    end
    drain("drain1", 4);
    bus_rd("drained", 16'hFF03, 8'h0E, 1'b1);
    bus_wr(16'hFF03, 8'h08);
    bus_rd("ovf_clr", 16'hFF03, 8'h06, 1'b1);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) begin
      bus_wr(16'hFF02, 8'hA1 + 8'(i));
      tx_exp_q.push_back(8'hA1 + 8'(i));
    end
    tx_exp_q.push_back(8'h77);
    check8("head_a1", tx_data, tx_exp_q.pop_front());
    tx_ready = 1'b1;
    bus_wr(16'hFF02, 8'h77);
    tx_ready = 1'b0;
    bus_rd("full_pushpop", 16'hFF03, 8'h45, 1'b1);
    drain("drain2", 4);

    // Asynchronous reset while the timer runs
    bus_wr(16'hFF05, 8'h01);
    bus_wr(16'hFF04, 8'h00);
    bus_wr(16'hFF06, 8'h01);
    repeat (3) tick();
    bus_wr(16'hFF02, 8'h99);
    bus_rd("pre_rst", 16'hFF00, 8'h33, 1'b1);
    check1("pre_rst_valid", tx_valid, 1'b1);
    reset = 1'b0;
    #2;
    check8("arst_q", q, 8'h00);
    check1("arst_hit", io_hit, 1'b0);
    check8("arst_gpio", gpio_out, 8'h00);
    check1("arst_valid", tx_valid, 1'b0);
    check8("arst_txdata", tx_data, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    bus_rd("post_status", 16'hFF03, 8'h02, 1'b1);
    bus_rd("post_tctrl", 16'hFF06, 8'h00, 1'b1);
    bus_rd("post_rhi", 16'hFF05, 8'h00, 1'b1);
    repeat (3) tick();
    bus_rd("post_idle", 16'hFF03, 8'h02, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
